// File: rtl/minterm_scan_ctrl.sv
// Sweeps the evaluator select code through 0..N-1 and samples f once per code.
// It commits the captured truth table, its popcount and a golden-compare flag.
module minterm_scan_ctrl #(
  parameter  int WIDTH  = 3,
  parameter  int SETTLE = 2,
  localparam int N      = 1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             f_in,
  input  logic [N-1:0]     expected,
  output logic [WIDTH-1:0] w_out,
  output logic [N-1:0]     tt,
  output logic [WIDTH:0]   ones,
  output logic             match,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0]       SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [WIDTH-1:0] LAST_W    = WIDTH'(N - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_d;
  logic [3:0]       cnt, cnt_d;
  logic [WIDTH-1:0] w_d;
  logic [N-1:0]     shadow, shadow_d, merged;
  logic             commit;

  function automatic logic [WIDTH:0] popcnt(input logic [N-1:0] v);
    popcnt = '0;
    for (int k = 0; k < N; k++) popcnt += {{WIDTH{1'b0}}, v[k]};
  endfunction

  always_comb begin
    state_d   = state;
    w_d       = w_out;
    cnt_d     = cnt;
    shadow_d  = shadow;
    commit    = 1'b0;
    // Commit takes the table with the final sample already merged in.
    merged        = shadow;
    merged[w_out] = f_in;
    case (state)
      IDLE: begin
        w_d = '0;
        if (start && !abort) begin
          state_d  = SCAN;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          w_d     = '0;
          cnt_d   = '0;
        end else if (cnt == SETTLE_M1) begin
          cnt_d    = '0;
          shadow_d = merged;
          if (w_out == LAST_W) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            w_d = w_out + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        w_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      w_out  <= '0;
      cnt    <= '0;
      shadow <= '0;
      tt     <= '0;
      ones   <= '0;
      match  <= 1'b0;
    end else begin
      state  <= state_d;
      w_out  <= w_d;
      cnt    <= cnt_d;
      shadow <= shadow_d;
      if (commit) begin
        tt    <= merged;
        ones  <= popcnt(merged);
        match <= (merged == expected);
      end
    end
  end

  assign busy = (state == SCAN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_minterm_scan_ctrl.sv
// Bench for minterm_scan_ctrl: two instances (SETTLE=2 and SETTLE=1) are checked
// every cycle against a scan-position model, plus directed literal checks.
module tb_minterm_scan_ctrl;

  logic       clk, rst_n;
  logic       st[2], ab[2], f[2], rb[2];
  logic [7:0] exp_v[2];
  int         fmode[2];
  logic [2:0] w_o[2];
  logic [7:0] tt_o[2];
  logic [3:0] ones_o[2];
  logic       match_o[2], busy_o[2], done_o[2];

  int passed = 0, total = 0, cyc = 0;
  bit chk_en = 0;

  // model: mode 0 idle, 1 scanning, 2 done; pos = cycles spent in the scan
  int         m_mode[2] = '{default: 0};
  int         m_pos[2]  = '{default: 0};
  logic [7:0] m_sh[2]   = '{default: 0};
  logic [7:0] m_tt[2]   = '{default: 0};
  int         m_ones[2] = '{default: 0};
  logic       m_match[2] = '{default: 0};

  minterm_scan_ctrl #(.WIDTH(3), .SETTLE(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]), .f_in(f[0]),
    .expected(exp_v[0]), .w_out(w_o[0]), .tt(tt_o[0]), .ones(ones_o[0]),
    .match(match_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  minterm_scan_ctrl #(.WIDTH(3), .SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]), .f_in(f[1]),
    .expected(exp_v[1]), .w_out(w_o[1]), .tt(tt_o[1]), .ones(ones_o[1]),
    .match(match_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sfor(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // evaluator stand-ins: 0 decoder function, 1 glitch-then-0, 2 random, 3 tied high
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      case (fmode[i])
        0:       f[i] = (w_o[i] == 3'd2) || (w_o[i] >= 3'd5);
        1:       f[i] = (m_pos[i] % 2 == 0);
        2:       f[i] = rb[i];
        default: f[i] = 1'b1;
      endcase
    end
  end

  always @(posedge clk) begin
    rb[0] <= 1'($urandom);
    rb[1] <= 1'($urandom);
  end

  always @(posedge clk or negedge rst_n) begin : model
    int md, ps, s;
    logic [7:0] sh;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] <= 0; m_pos[i] <= 0; m_sh[i] <= '0;
        m_tt[i] <= '0; m_ones[i] <= 0; m_match[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        md = m_mode[i]; ps = m_pos[i]; sh = m_sh[i]; s = sfor(i);
        case (md)
          0: if (st[i] && !ab[i]) begin md = 1; ps = 0; sh = '0; end
          1: begin
            if (ab[i]) begin
              md = 0; ps = 0;
            end else begin
              if (ps % s == s - 1) sh[ps / s] = f[i];
              ps++;
              if (ps == 8 * s) begin
                md = 2;
                m_tt[i]    <= sh;
                m_ones[i]  <= $countones(sh);
                m_match[i] <= (sh == exp_v[i]);
              end
            end
          end
          default: md = 0;
        endcase
        m_mode[i] <= md; m_pos[i] <= ps; m_sh[i] <= sh;
      end
    end
  end

  task automatic chk(string nm, int act, int ex);
    total++;
    if (act != ex) $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                            nm, act, act, ex, ex, cyc);
    else passed++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int ew;
        ew = (m_mode[i] == 1) ? m_pos[i] / sfor(i) : (m_mode[i] == 2 ? 7 : 0);
        chk($sformatf("w_out%0d", i), w_o[i], ew);
        chk($sformatf("tt%0d", i),    tt_o[i], m_tt[i]);
        chk($sformatf("ones%0d", i),  ones_o[i], m_ones[i]);
        chk($sformatf("match%0d", i), match_o[i], m_match[i]);
        chk($sformatf("busy%0d", i),  busy_o[i], m_mode[i] == 1);
        chk($sformatf("done%0d", i),  done_o[i], m_mode[i] == 2);
      end
    end
  end

  // pulse start, return edges from the start edge until done is seen high
  task automatic run_scan(int i, output int lat);
    st[i] = 1'b1;
    @(posedge clk); #1;
    st[i] = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done_o[i]) begin lat = n; break; end
    end
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_done(int i, output int at);
    at = -1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (done_o[i]) begin at = cyc; break; end
    end
    if (at < 0) chk("done_wait_timeout", 0, 1);
  endtask

  task automatic wait_w(int i, int code);
    bit hit;
    hit = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (w_o[i] == 3'(code)) begin hit = 1; break; end
    end
    if (!hit) chk("w_wait_timeout", 0, 1);
  endtask

  initial begin
    int lat, t1, t2, t3;
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin st[i] = 0; ab[i] = 0; exp_v[i] = '0; fmode[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_tt", tt_o[0], 0);
    chk("rst_busy", busy_o[0], 0);
    chk("rst_w", w_o[0], 0);
    chk_en = 1;
    @(posedge clk); #1;

    // decoder function (w==2)|(w>=5), golden E4
    exp_v[0] = 8'hE4;
    run_scan(0, lat);
    chk("latency_s2", lat, 16);
    chk("tt_e4", tt_o[0], 8'hE4);
    chk("ones_e4", ones_o[0], 4);
    chk("match_e4", match_o[0], 1);
    @(posedge clk); #1;
    exp_v[0] = 8'hE5;
    run_scan(0, lat);
    chk("match_e5", match_o[0], 0);
    chk("tt_e5run", tt_o[0], 8'hE4);
    @(posedge clk); #1;

    // abort at w_out=3 keeps the earlier commit
    st[0] = 1; @(posedge clk); #1; st[0] = 0;
    wait_w(0, 3);
    ab[0] = 1; @(posedge clk); #1; ab[0] = 0;
    chk("abort_busy", busy_o[0], 0);
    chk("abort_w", w_o[0], 0);
    chk("abort_tt", tt_o[0], 8'hE4);
    chk("abort_done", done_o[0], 0);
    repeat (20) @(posedge clk); #1;

    // first-cycle glitch must be ignored
    fmode[0] = 1;
    run_scan(0, lat);
    chk("glitch_tt", tt_o[0], 8'h00);
    chk("glitch_ones", ones_o[0], 0);
    @(posedge clk); #1;

    // start held high: periodic done, no restart mid-scan
    fmode[0] = 0;
    st[0] = 1;
    wait_done(0, t1);
    wait_done(0, t2);
    wait_done(0, t3);
    chk("period1", t2 - t1, 18);
    chk("period2", t3 - t2, 18);
    st[0] = 0;
    repeat (25) @(posedge clk); #1;

    // SETTLE=1, f tied high
    fmode[1] = 3;
    run_scan(1, lat);
    chk("latency_s1", lat, 8);
    chk("tt_ff", tt_o[1], 8'hFF);
    chk("ones_8", ones_o[1], 8);
    @(posedge clk); #1;
    st[1] = 1; ab[1] = 1;
    @(posedge clk); #1;
    chk("start_abort_busy", busy_o[1], 0);
    st[1] = 0; ab[1] = 0;
    @(posedge clk); #1;

    // randomized traffic on both instances
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        st[i] = ($urandom % 6 == 0);
        ab[i] = ($urandom % 50 == 0);
        if (n % 64 == 0) begin
          fmode[i] = $urandom % 4;
          case ($urandom % 4)
            0: exp_v[i] = 8'hE4;
            1: exp_v[i] = 8'hFF;
            2: exp_v[i] = 8'h00;
            default: exp_v[i] = 8'($urandom);
          endcase
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin st[i] = 0; ab[i] = 0; end
    repeat (25) @(posedge clk); #1;

    // asynchronous reset in the middle of a scan
    fmode[0] = 0;
    st[0] = 1; @(posedge clk); #1; st[0] = 0;
    wait_w(0, 5);
    #1 rst_n = 0;
    #1;
    chk("arst_w", w_o[0], 0);
    chk("arst_busy", busy_o[0], 0);
    chk("arst_tt", tt_o[0], 0);
    chk("arst_ones", ones_o[0], 0);
    #10 rst_n = 1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
